// File: rtl/cmd_parser_pkg.sv
// Shared types and constants for the ASCII "M<hex>CRLF" command parser.
// The optional error counter is enabled with CMD_PARSER_ERR_COUNT_EN.
package cmd_parser_pkg;

  localparam int ADDR_WIDTH = 16;
  localparam int DATA_WIDTH = 16;

  localparam logic [7:0] CHAR_M  = 8'h4D;
  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  localparam logic [3:0] READ_DIGITS  = 4'd4;
  localparam logic [3:0] WRITE_DIGITS = 4'd8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BODY      = 2'd1,
    EXPECT_LF = 2'd2
  } state_e;

endpackage

// File: rtl/cmd_parser_hex_digit_decode.sv
// Combinational ASCII hex digit decoder: '0'-'9', 'A'-'F', 'a'-'f' -> nibble.
module hex_digit_decode (
  input  logic [7:0] ascii_i,
  output logic [3:0] nib_o,
  output logic       is_hex_o
);

  always_comb begin
    nib_o    = 4'd0;
    is_hex_o = 1'b0;
    if (ascii_i >= 8'h30 && ascii_i <= 8'h39) begin
      nib_o    = ascii_i[3:0];
      is_hex_o = 1'b1;
    end else if ((ascii_i >= 8'h41 && ascii_i <= 8'h46) ||
                 (ascii_i >= 8'h61 && ascii_i <= 8'h66)) begin
      // 'A'/'a' have low nibble 1, so adding 9 yields 10..15
      nib_o    = ascii_i[3:0] + 4'd9;
      is_hex_o = 1'b1;
    end
  end

endmodule

// File: rtl/cmd_parser.sv
// Byte-stream decoder turning "M"+4 hex (read) or "M"+8 hex (write) + CRLF into bus requests.
// Define CMD_PARSER_ERR_COUNT_EN to add a saturating 16-bit err_count_o port.
module cmd_parser
  import cmd_parser_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic                  rw_o,
  output logic                  valid_o,
`ifdef CMD_PARSER_ERR_COUNT_EN
  output logic [15:0]           err_count_o,
`endif
  output logic                  err_o
);

  state_e                  state_q;
  logic [3:0]              cnt_q;
  logic [31:0]             buf_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    rw_q;
  logic                    valid_q;
  logic                    err_q;

  logic [3:0]              nib_d;
  logic                    is_hex_d;

  hex_digit_decode u_hex (
    .ascii_i  (rx_data),
    .nib_o    (nib_d),
    .is_hex_o (is_hex_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      buf_q   <= 32'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (rx_valid) begin
        unique case (state_q)
          IDLE: begin
            if (rx_data == CHAR_M) begin
              state_q <= BODY;
              cnt_q   <= 4'd0;
              buf_q   <= 32'd0;
            end
          end
          BODY: begin
            if (rx_data == CHAR_M) begin
              cnt_q <= 4'd0;
              buf_q <= 32'd0;
            end else if (is_hex_d) begin
              if (cnt_q < WRITE_DIGITS) begin
                buf_q <= {buf_q[27:0], nib_d};
                cnt_q <= cnt_q + 4'd1;
              end else begin
                err_q   <= 1'b1;
                state_q <= IDLE;
              end
            end else if (rx_data == CHAR_CR &&
                         (cnt_q == READ_DIGITS || cnt_q == WRITE_DIGITS)) begin
              state_q <= EXPECT_LF;
            end else begin
              err_q   <= 1'b1;
              state_q <= IDLE;
            end
          end
          EXPECT_LF: begin
            if (rx_data == CHAR_LF) begin
              valid_q <= 1'b1;
              state_q <= IDLE;
              if (cnt_q == WRITE_DIGITS) begin
                rw_q    <= 1'b1;
                addr_q  <= buf_q[31:16];
                wdata_q <= buf_q[15:0];
              end else begin
                rw_q    <= 1'b0;
                addr_q  <= buf_q[15:0];
                wdata_q <= '0;
              end
            end else if (rx_data == CHAR_M) begin
              // A fresh 'M' still faults the pending frame but starts the next one
              err_q   <= 1'b1;
              state_q <= BODY;
              cnt_q   <= 4'd0;
              buf_q   <= 32'd0;
            end else begin
              err_q   <= 1'b1;
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;
  assign rw_o    = rw_q;
  assign valid_o = valid_q;
  assign err_o   = err_q;

`ifdef CMD_PARSER_ERR_COUNT_EN
  logic [15:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= 16'd0;
    end else if (err_q && err_cnt_q != 16'hFFFF) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_count_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_cmd_parser.sv
// Scoreboard bench for cmd_parser: stimulus pushes expected requests/errors, a monitor pops on each strobe.
module tb_cmd_parser;

  typedef struct packed {
    logic        is_err;
    logic        rw;
    logic [15:0] addr;
    logic [15:0] wdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [15:0] addr_o;
  logic [15:0] wdata_o;
  logic        rw_o;
  logic        valid_o;
  logic        err_o;
`ifdef CMD_PARSER_ERR_COUNT_EN
  logic [15:0] err_count_o;
`endif

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   n_valid = 0;
  int   exp_errs = 0;
  int   gap = 9;

  always #5 clk = ~clk;

  cmd_parser dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .addr_o   (addr_o),
    .wdata_o  (wdata_o),
    .rw_o     (rw_o),
    .valid_o  (valid_o),
`ifdef CMD_PARSER_ERR_COUNT_EN
    .err_count_o (err_count_o),
`endif
    .err_o    (err_o)
  );

  task automatic check(input string name, input bit ok, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (valid_o || err_o)) begin
      if (valid_o) n_valid++;
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 1'b0,
              {30'd0, err_o, valid_o, rw_o, addr_o, wdata_o}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        if (e.is_err)
          check("err_pulse", err_o && !valid_o,
                {30'd0, err_o, valid_o, rw_o, addr_o, wdata_o},
                {30'd0, 1'b1, 1'b0, rw_o, addr_o, wdata_o});
        else
          check(e.rw ? "write_req" : "read_req",
                valid_o && !err_o && rw_o == e.rw && addr_o == e.addr && wdata_o == e.wdata,
                {30'd0, err_o, valid_o, rw_o, addr_o, wdata_o},
                {30'd0, 1'b0, 1'b1, e.rw, e.addr, e.wdata});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic send_frame(input string s);
    send_str(s);
    send_byte(8'h0D);
    send_byte(8'h0A);
  endtask

  task automatic push_rd(input logic [15:0] a);
    exp_t e;
    e = '{is_err: 1'b0, rw: 1'b0, addr: a, wdata: 16'h0000};
    exp_q.push_back(e);
  endtask

  task automatic push_wr(input logic [15:0] a, input logic [15:0] d);
    exp_t e;
    e = '{is_err: 1'b0, rw: 1'b1, addr: a, wdata: d};
    exp_q.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e = '{is_err: 1'b1, rw: 1'b0, addr: 16'h0, wdata: 16'h0};
    exp_q.push_back(e);
    exp_errs++;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    check(name, exp_q.size() == 0, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    int v0;
    logic [15:0] a, d;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_outputs", {addr_o, wdata_o, rw_o, valid_o, err_o} == 35'd0,
          64'({addr_o, wdata_o, rw_o, valid_o, err_o}), 64'd0);

    // Garbage before 'M' is ignored, then a plain read
    send_str("xyz");
    push_rd(16'h1234);
    send_frame("M1234");
    drain("read_1234");
    repeat (5) @(posedge clk);
    #1;
    check("hold_after_read", addr_o == 16'h1234 && !valid_o && !rw_o,
          64'({valid_o, rw_o, addr_o}), 64'h0_1234);

    push_wr(16'h12AB, 16'h5678);
    send_frame("M12ab5678");
    drain("write_12ab");

    // Malformed frames, then recovery
    push_err(); send_frame("M12G4");
    push_err(); send_frame("M123");
    push_err(); send_frame("M123456789");
    push_rd(16'h0001); send_frame("M0001");
    drain("malformed");

    push_rd(16'h0005); send_frame("M12M0005");
    drain("resync");

    // Bad byte in place of LF: an 'M' faults and restarts, others fault to IDLE
    push_err(); push_rd(16'h0002);
    send_str("M1234"); send_byte(8'h0D); send_frame("M0002");
    push_err();
    send_str("MABCD"); send_byte(8'h0D); send_byte(8'h78);
    drain("expect_lf_errors");

    // Reset mid-frame
    send_str("M12");
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_errs = 0;
    check("midframe_reset_outputs", {addr_o, wdata_o, rw_o, valid_o, err_o} == 35'd0,
          64'({addr_o, wdata_o, rw_o, valid_o, err_o}), 64'd0);
    send_byte(8'h0A);
    push_rd(16'h00FF); send_frame("M00FF");
    drain("after_reset");

    // Back-to-back stress with no idle cycles between bytes
    gap = 0;
    v0 = n_valid;
    for (int i = 0; i < 100; i++) begin
      a = 16'(i * 16'h0137) ^ 16'h5A5A;
      push_rd(a);
      send_frame($sformatf("M%04h", a));
    end
    for (int i = 0; i < 100; i++) begin
      a = 16'hA000 + 16'(i);
      d = ~16'(i * 3);
      push_wr(a, d);
      send_frame($sformatf("M%04h%04h", a, d));
    end
    gap = 2;
    drain("stress_drain");
    check("stress_pulses", n_valid - v0 == 200, 64'(n_valid - v0), 64'd200);

    push_err(); send_frame("M12G4");
    push_err(); send_frame("M12");
    push_err(); send_frame("M000000000");
    drain("bad_frames");
`ifdef CMD_PARSER_ERR_COUNT_EN
    check("err_count", err_count_o == 16'(exp_errs), 64'(err_count_o), 64'(exp_errs));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cmd_parser.md
Name: cmd_parser

Overview:
- Byte-stream command decoder between the UART receiver (rx_uart, 8-bit o_data/o_wr) and the memory-mapped bus (lut_mem addr_i/wdata_i/rw_i/valid_i).
- Parses ASCII frames: "M" + 4 hex digits + CR LF is a read; "M" + 8 hex digits + CR LF is a write.
- Issues one single-cycle bus request per valid frame. Malformed frames are dropped and flagged.

Parameters:
- ADDR_WIDTH, 16, bus address width; fixed at 4 hex digits.
- DATA_WIDTH, 16, bus write-data width; fixed at 4 hex digits.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  rx_data valid for this cycle; single-cycle strobe, no backpressure.
- addr_o  out  16  bus address.
- wdata_o  out  16  bus write data; 0 for reads.
- rw_o  out  1  1 = write, 0 = read.
- valid_o  out  1  one-cycle request strobe.
- err_o  out  1  one-cycle strobe on a malformed frame.

Behaviour:
- Single clock clk. Reset is synchronous, active-high on rst.
- Reset values: addr_o=0, wdata_o=0, rw_o=0, valid_o=0, err_o=0. State = IDLE, digit count = 0, shift buffer = 0.
- Reset asserted mid-frame discards the partial frame; no valid_o or err_o is produced for it.
- Bytes are examined only on cycles with rx_valid=1. With rx_valid=0, state and outputs hold, except valid_o and err_o, which are forced to 0.
- Hex digits accepted: '0'-'9', 'A'-'F', 'a'-'f'.
- Each accepted digit shifts its nibble into a 32-bit buffer from the LSB end: buf <= {buf[27:0], nib}. The digit count increments.
- States:
  - IDLE: 'M' -> BODY (count=0, buf=0). Any other byte is ignored silently.
  - BODY:
    - hex digit with count<8 -> shift, stay in BODY.
    - hex digit with count==8 -> error.
    - CR with count==4 or 8 -> EXPECT_LF.
    - CR with any other count -> error.
    - 'M' -> restart BODY (count=0, buf=0), no error.
    - any other byte -> error.
  - EXPECT_LF:
    - LF -> issue request, go to IDLE.
    - 'M' -> error, then BODY (restart).
    - any other byte -> error, go to IDLE.
- Error action: err_o=1 for exactly the cycle after the offending byte. State goes to IDLE (or to BODY if the offending byte was 'M'). No bus request is issued.
- Request action, in the cycle after the LF byte:
  - valid_o=1 for one cycle.
  - count==4 -> rw_o=0, addr_o=buf[15:0], wdata_o=0.
  - count==8 -> rw_o=1, addr_o=buf[31:16], wdata_o=buf[15:0].
- Latency: LF byte accepted at cycle N -> valid_o high at cycle N+1.
- addr_o, wdata_o and rw_o hold their values after valid_o deasserts, until the next request.
- Back-to-back frames need no idle gap. Minimum frame spacing is dictated by the UART, so request collision cannot occur.

Optional Feature:
- Macro CMD_PARSER_ERR_COUNT_EN.
- Defined: adds output port err_count_o (16 bits). It increments on every err_o pulse, saturates at 0xFFFF, and is cleared by rst.
- Undefined: no port and no counter logic. err_o behaviour is identical in both builds.

Decomposition:
- Package cmd_parser_pkg:
  - state enum (IDLE, BODY, EXPECT_LF);
  - ASCII constants CHAR_M=8'h4D, CHAR_CR=8'h0D, CHAR_LF=8'h0A;
  - READ_DIGITS=4, WRITE_DIGITS=8.
- Sub-module hex_digit_decode: combinational 8-bit ASCII in -> 4-bit nibble + is_hex flag. Instantiated once.

Test Plan:
- Read: send "M1234"+CR+LF at 10 clocks/bit -> one valid_o pulse, rw_o=0, addr_o=0x1234, wdata_o=0, err_o never high.
- Write, lowercase: send "M12ab5678"+CR+LF -> one pulse, rw_o=1, addr_o=0x12AB, wdata_o=0x5678. Read back "M12ab"+CR+LF through lut_mem returns 0x5678 via bridge_tx.
- Malformed: "M12G4"+CR+LF, "M123"+CR+LF, and "M123456789"+CR+LF -> one err_o pulse each, zero valid_o pulses, parser accepts the next "M0001"+CR+LF normally.
- Resync: "M12M0005"+CR+LF -> single read of addr 0x0005, no err_o. Garbage "xyz" before 'M' is ignored silently.
- Reset mid-frame: assert rst for 1 cycle after "M12" -> no pulses. Subsequent "LF" alone is ignored. "M00FF"+CR+LF yields addr_o=0x00FF.
- Stress, with CMD_PARSER_ERR_COUNT_EN defined: 100 reads + 100 writes back-to-back -> exactly 200 valid_o pulses. Then 3 bad frames -> err_count_o=3.
